// File: rtl/pr_block_responder.sv
// Responder end of the PR control handshake: receives MAGIC, LEN, payload, CSUM frames and reports done/error.
// Optional build macro PR_RESP_ERR_INJECT_EN adds inject_csum_err to force a checksum failure.
module pr_block_responder #(
  parameter int                        DATA_REG_WIDTH = 16,
  parameter logic [DATA_REG_WIDTH-1:0] PR_MAGIC       = 16'hA55A,
  parameter int                        MAX_WORDS      = 1024,
  parameter int                        READY_DELAY    = 4,
  parameter int                        TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pr_request,
  input  logic [DATA_REG_WIDTH-1:0] pr_data,
  input  logic                      pr_data_valid,
  output logic                      pr_ready,
  output logic                      pr_done,
  output logic                      pr_error,
  output logic                      busy,
  output logic [2:0]                err_code,
  output logic [15:0]               words_rcvd
`ifdef PR_RESP_ERR_INJECT_EN
  ,
  input  logic                      inject_csum_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_HDR,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_MAGIC   = 3'd1;
  localparam logic [2:0] ERR_LENGTH  = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_ABORT   = 3'd5;

  localparam int PREP_W = (READY_DELAY > 1) ? $clog2(READY_DELAY) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PREP_W-1:0]         PREP_LAST = PREP_W'(READY_DELAY - 1);
  localparam logic [TMO_W-1:0]          TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_REG_WIDTH:0]   MAX_LEN   = (DATA_REG_WIDTH + 1)'(MAX_WORDS);
  localparam logic [DATA_REG_WIDTH-1:0] REM_ONE   = DATA_REG_WIDTH'(1);

  state_t                    state_q, state_d;
  logic [PREP_W-1:0]         prep_cnt_q, prep_cnt_d;
  logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [DATA_REG_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_REG_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]               words_q, words_d;
  logic [2:0]                err_q, err_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic                      busy_q, busy_d;
  logic                      accept;
  logic                      csum_force;

`ifdef PR_RESP_ERR_INJECT_EN
  logic inj_q, inj_d;
  assign csum_force = inj_q | inject_csum_err;
`else
  assign csum_force = 1'b0;
`endif

  assign accept = pr_data_valid && ready_q;

  // Next-state logic; every output is derived from the next state so all outputs come straight off flops.
  always_comb begin
    state_d    = state_q;
    prep_cnt_d = prep_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    words_d    = words_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (pr_request) begin
          state_d    = S_PREP;
          prep_cnt_d = '0;
          words_d    = '0;
          err_d      = ERR_NONE;
          acc_d      = '0;
        end
      end

      S_PREP: begin
        if (!pr_request) begin
          state_d = S_DONE;
          err_d   = ERR_ABORT;
        end else if (prep_cnt_q == PREP_LAST) begin
          state_d   = S_HDR;
          tmo_cnt_d = '0;
        end else begin
          prep_cnt_d = prep_cnt_q + PREP_W'(1);
        end
      end

      S_HDR, S_LEN, S_DATA, S_CSUM: begin
        // Abort wins over both a same-cycle word and a timeout.
        if (!pr_request) begin
          state_d = S_DONE;
          err_d   = ERR_ABORT;
        end else if (accept) begin
          tmo_cnt_d = '0;
          case (state_q)
            S_HDR: begin
              if (pr_data != PR_MAGIC) begin
                state_d = S_DONE;
                err_d   = ERR_MAGIC;
              end else begin
                state_d = S_LEN;
              end
            end
            S_LEN: begin
              if ({1'b0, pr_data} > MAX_LEN) begin
                state_d = S_DONE;
                err_d   = ERR_LENGTH;
              end else if (pr_data == '0) begin
                state_d = S_CSUM;
              end else begin
                state_d = S_DATA;
                rem_d   = pr_data;
              end
            end
            S_DATA: begin
              acc_d = acc_q + pr_data;
              if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
              if (rem_q == REM_ONE) state_d = S_CSUM;
              else                  rem_d   = rem_q - REM_ONE;
            end
            default: begin
              state_d = S_DONE;
              if ((pr_data != acc_q) || csum_force) err_d = ERR_CSUM;
            end
          endcase
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_DONE;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      S_DONE: begin
        if (!pr_request) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_HDR) || (state_d == S_LEN) ||
              (state_d == S_DATA) || (state_d == S_CSUM);
    done_d  = (state_d == S_DONE);
    error_d = done_d && (err_d != ERR_NONE);
    busy_d  = (state_d != S_IDLE);
  end

`ifdef PR_RESP_ERR_INJECT_EN
  // Injection request is sticky from session start until the next session clears it.
  always_comb begin
    inj_d = inj_q;
    if (state_q == S_IDLE) begin
      if (pr_request) inj_d = inject_csum_err;
    end else if (state_q != S_DONE && inject_csum_err) begin
      inj_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prep_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      words_q    <= '0;
      err_q      <= ERR_NONE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PR_RESP_ERR_INJECT_EN
      inj_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prep_cnt_q <= prep_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      words_q    <= words_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
`ifdef PR_RESP_ERR_INJECT_EN
      inj_q      <= inj_d;
`endif
    end
  end

  assign pr_ready   = ready_q;
  assign pr_done    = done_q;
  assign pr_error   = error_q;
  assign busy       = busy_q;
  assign err_code   = err_q;
  assign words_rcvd = words_q;

endmodule

// File: tb/tb_pr_block_responder.sv
// Self-checking bench for pr_block_responder: directed frames plus random frames scored by a frame-level model.
module tb_pr_block_responder;

  localparam int          RD    = 4;
  localparam int          TMO   = 256;
  localparam int          MAXW  = 1024;
  localparam logic [15:0] MAGIC = 16'hA55A;

  typedef logic [15:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pr_request;
  logic [15:0] pr_data;
  logic        pr_data_valid;
  logic        pr_ready;
  logic        pr_done;
  logic        pr_error;
  logic        busy;
  logic [2:0]  err_code;
  logic [15:0] words_rcvd;
`ifdef PR_RESP_ERR_INJECT_EN
  logic        inject_csum_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pr_block_responder #(
    .DATA_REG_WIDTH(16),
    .PR_MAGIC      (MAGIC),
    .MAX_WORDS     (MAXW),
    .READY_DELAY   (RD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pr_request   (pr_request),
    .pr_data      (pr_data),
    .pr_data_valid(pr_data_valid),
    .pr_ready     (pr_ready),
    .pr_done      (pr_done),
    .pr_error     (pr_error),
    .busy         (busy),
    .err_code     (err_code),
    .words_rcvd   (words_rcvd)
`ifdef PR_RESP_ERR_INJECT_EN
    ,
    .inject_csum_err(inject_csum_err)
`endif
  );

  // Frame-level reference: expected error code, payload count and how many words the responder consumes.
  function automatic void model_frame(input wq_t fr, output int e, output int nw, output int used);
    logic [15:0] sum;
    int len;
    sum = '0;
    nw = 0;
    if (fr[0] != MAGIC) begin e = 1; used = 1; return; end
    len = int'(fr[1]);
    if (len > MAXW) begin e = 2; used = 2; return; end
    for (int i = 0; i < len; i++) sum = sum + fr[2+i];
    nw = len;
    used = len + 3;
    e = (fr[len+2] == sum) ? 0 : 3;
  endfunction

  function automatic wq_t gen_frame();
    wq_t f;
    int kind;
    int len;
    logic [15:0] s;
    logic [15:0] w;
    kind = int'($urandom_range(9, 0));
    len = int'($urandom_range(6, 0));
    s = '0;
    if (kind == 0) begin
      f.push_back(MAGIC ^ 16'($urandom_range(65535, 1)));
      return f;
    end
    f.push_back(MAGIC);
    if (kind == 1) begin
      f.push_back(16'($urandom_range(65535, MAXW + 1)));
      return f;
    end
    f.push_back(16'(len));
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      s = s + w;
      f.push_back(w);
    end
    f.push_back((kind == 2) ? (s ^ 16'($urandom_range(65535, 1))) : s);
    return f;
  endfunction

  task automatic run_frame(input wq_t fr, input int used, input int max_gap, output bit ok);
    int n;
    ok = 1'b1;
    pr_request = 1'b1;
    n = 0;
    while (!pr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pr_ready) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < used; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        pr_data_valid = 1'b0;
        @(posedge clk); #1;
      end
      pr_data_valid = 1'b1;
      pr_data = fr[i];
      @(posedge clk); #1;
    end
    pr_data_valid = 1'b0;
  endtask

  task automatic end_session();
    pr_request = 1'b0;
    pr_data_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pr_request = 1'b0;
    pr_data_valid = 1'b0;
    pr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pr_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", pr_ready); end
    checks++; if (pr_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", pr_done); end
    checks++; if (pr_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error got=%b exp=0", pr_error); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_code !== 3'd0) begin failures++; $display("[TB] FAIL reset_err_code got=%0d exp=0", err_code); end
    checks++; if (words_rcvd !== 16'd0) begin failures++; $display("[TB] FAIL reset_words got=%0d exp=0", words_rcvd); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Valid is held high through PREP to show words are ignored until pr_ready.
  task automatic test_ready_latency();
    wq_t f;
    int n;
    int e, nw, used;
    bit ok;
    logic [15:0] held_words;
    pr_request = 1'b1;
    pr_data_valid = 1'b1;
    pr_data = MAGIC;
    n = 0;
    while (!pr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    pr_data_valid = 1'b0;
    checks++; if (n !== RD + 1) begin failures++; $display("[TB] FAIL ready_latency got=%0d exp=%0d", n, RD + 1); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ready_busy got=%b exp=1", busy); end
    checks++; if (words_rcvd !== 16'd0) begin failures++; $display("[TB] FAIL prep_words got=%0d exp=0", words_rcvd); end
    f.push_back(MAGIC);
    f.push_back(16'd2);
    f.push_back(16'h1111);
    f.push_back(16'h2222);
    f.push_back(16'h3333);
    model_frame(f, e, nw, used);
    run_frame(f, used, 0, ok);
    checks++; if (pr_done !== 1'b1 || err_code !== 3'd0) begin failures++; $display("[TB] FAIL latency_frame done=%b err=%0d exp done=1 err=0", pr_done, err_code); end
    held_words = words_rcvd;
    pr_data_valid = 1'b1;
    pr_data = 16'h5A5A;
    repeat (2) @(posedge clk);
    #1;
    pr_data_valid = 1'b0;
    checks++; if (words_rcvd !== 16'd2 || held_words !== 16'd2) begin failures++; $display("[TB] FAIL done_ignores_valid words=%0d exp=2", words_rcvd); end
    checks++; if (pr_done !== 1'b1 || pr_ready !== 1'b0) begin failures++; $display("[TB] FAIL done_hold done=%b ready=%b exp done=1 ready=0", pr_done, pr_ready); end
    end_session();
    checks++; if (pr_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL done_release done=%b busy=%b exp 0 0", pr_done, busy); end
  endtask

  task automatic test_spec_frames();
    int exp_err[6] = '{0, 1, 2, 0, 3, 0};
    int exp_w[6]   = '{3, 0, 0, 0, 3, 2};
    int e, nw, used;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      wq_t f;
      case (k)
        0: begin f.push_back(MAGIC); f.push_back(16'h0003); f.push_back(16'h0001); f.push_back(16'h0002); f.push_back(16'h0003); f.push_back(16'h0006); end
        1: begin f.push_back(16'h1234); end
        2: begin f.push_back(MAGIC); f.push_back(16'(MAXW + 1)); end
        3: begin f.push_back(MAGIC); f.push_back(16'h0000); f.push_back(16'h0000); end
        4: begin f.push_back(MAGIC); f.push_back(16'h0003); f.push_back(16'h0001); f.push_back(16'h0002); f.push_back(16'h0003); f.push_back(16'h0007); end
        default: begin f.push_back(MAGIC); f.push_back(16'h0002); f.push_back(16'hFFFF); f.push_back(16'h0002); f.push_back(16'h0001); end
      endcase
      model_frame(f, e, nw, used);
      run_frame(f, used, 1, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL spec%0d_ready_wait got=timeout exp=ready", k); end
      checks++; if (pr_done !== 1'b1) begin failures++; $display("[TB] FAIL spec%0d_done got=%b exp=1", k, pr_done); end
      checks++; if (pr_error !== (exp_err[k] != 0)) begin failures++; $display("[TB] FAIL spec%0d_error got=%b exp=%0d", k, pr_error, exp_err[k] != 0); end
      checks++; if (err_code !== 3'(exp_err[k])) begin failures++; $display("[TB] FAIL spec%0d_err_code got=%0d exp=%0d", k, err_code, exp_err[k]); end
      checks++; if (words_rcvd !== 16'(exp_w[k])) begin failures++; $display("[TB] FAIL spec%0d_words got=%0d exp=%0d", k, words_rcvd, exp_w[k]); end
      checks++; if (pr_ready !== 1'b0) begin failures++; $display("[TB] FAIL spec%0d_ready got=%b exp=0", k, pr_ready); end
      end_session();
    end
  endtask

  task automatic test_back_to_back();
    int e, nw, used;
    bit ok;
    for (int k = 0; k < 24; k++) begin
      wq_t f;
      f = gen_frame();
      model_frame(f, e, nw, used);
      run_frame(f, used, (k % 3 == 0) ? 0 : 3, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rand%0d_ready_wait got=timeout exp=ready", k); end
      checks++; if (pr_done !== 1'b1 || pr_error !== (e != 0)) begin failures++; $display("[TB] FAIL rand%0d_status done=%b error=%b exp done=1 error=%0d", k, pr_done, pr_error, e != 0); end
      checks++; if (err_code !== 3'(e)) begin failures++; $display("[TB] FAIL rand%0d_err_code got=%0d exp=%0d", k, err_code, e); end
      checks++; if (words_rcvd !== 16'(nw)) begin failures++; $display("[TB] FAIL rand%0d_words got=%0d exp=%0d", k, words_rcvd, nw); end
      end_session();
      checks++; if (pr_done !== 1'b0 || pr_error !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_idle done=%b error=%b busy=%b exp 0 0 0", k, pr_done, pr_error, busy); end
      checks++; if (err_code !== 3'(e)) begin failures++; $display("[TB] FAIL rand%0d_err_hold got=%0d exp=%0d", k, err_code, e); end
    end
  endtask

  task automatic test_timeout();
    wq_t f;
    bit ok;
    f.push_back(MAGIC);
    f.push_back(16'd3);
    run_frame(f, 2, 0, ok);
    repeat (TMO - 1) @(posedge clk);
    #1;
    checks++; if (pr_done !== 1'b0 || pr_ready !== 1'b1) begin failures++; $display("[TB] FAIL timeout_early done=%b ready=%b exp done=0 ready=1", pr_done, pr_ready); end
    @(posedge clk); #1;
    checks++; if (pr_done !== 1'b1 || pr_error !== 1'b1) begin failures++; $display("[TB] FAIL timeout_done done=%b error=%b exp 1 1", pr_done, pr_error); end
    checks++; if (err_code !== 3'd4) begin failures++; $display("[TB] FAIL timeout_err_code got=%0d exp=4", err_code); end
    end_session();
  endtask

  task automatic test_abort();
    wq_t f;
    bit ok;
    f.push_back(MAGIC);
    f.push_back(16'd5);
    f.push_back(16'($urandom));
    f.push_back(16'($urandom));
    run_frame(f, 4, 2, ok);
    pr_request = 1'b0;
    pr_data_valid = 1'b1;
    pr_data = 16'h0042;
    @(posedge clk); #1;
    pr_data_valid = 1'b0;
    checks++; if (pr_done !== 1'b1 || pr_error !== 1'b1) begin failures++; $display("[TB] FAIL abort_done done=%b error=%b exp 1 1", pr_done, pr_error); end
    checks++; if (err_code !== 3'd5) begin failures++; $display("[TB] FAIL abort_err_code got=%0d exp=5", err_code); end
    checks++; if (words_rcvd !== 16'd2) begin failures++; $display("[TB] FAIL abort_words got=%0d exp=2", words_rcvd); end
    @(posedge clk); #1;
    checks++; if (pr_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_idle done=%b busy=%b exp 0 0", pr_done, busy); end
  endtask

  task automatic test_reset_mid();
    wq_t f;
    bit ok;
    f.push_back(MAGIC);
    f.push_back(16'd6);
    f.push_back(16'h0101);
    f.push_back(16'h0202);
    run_frame(f, 4, 0, ok);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({pr_ready, pr_done, pr_error, busy} !== 4'b0000) begin failures++; $display("[TB] FAIL midreset_flags got=%b exp=0000", {pr_ready, pr_done, pr_error, busy}); end
    checks++; if (err_code !== 3'd0 || words_rcvd !== 16'd0) begin failures++; $display("[TB] FAIL midreset_counts err=%0d words=%0d exp 0 0", err_code, words_rcvd); end
    pr_request = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_after got=%b exp=0", busy); end
  endtask

`ifdef PR_RESP_ERR_INJECT_EN
  task automatic test_inject();
    wq_t f;
    bit ok;
    f.push_back(MAGIC);
    f.push_back(16'd3);
    f.push_back(16'd1);
    f.push_back(16'd2);
    f.push_back(16'd3);
    f.push_back(16'd6);
    pr_request = 1'b1;
    inject_csum_err = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inject_csum_err = 1'b0;
    run_frame(f, 6, 1, ok);
    checks++; if (err_code !== 3'd3 || pr_error !== 1'b1) begin failures++; $display("[TB] FAIL inject_err got=%0d exp=3", err_code); end
    end_session();
    run_frame(f, 6, 1, ok);
    checks++; if (err_code !== 3'd0 || pr_error !== 1'b0) begin failures++; $display("[TB] FAIL inject_cleared got=%0d exp=0", err_code); end
    end_session();
  endtask
`endif

  initial begin
`ifdef PR_RESP_ERR_INJECT_EN
    inject_csum_err = 1'b0;
`endif
    test_reset();
    test_ready_latency();
    test_spec_frames();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_mid();
`ifdef PR_RESP_ERR_INJECT_EN
    test_inject();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
